// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch PC owner plus circular {pc, instr} queue feeding decode over valid/ready.
// Optional IFQ_ALIGN_CHECK_EN adds a sticky misaligned-redirect flag.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_instr,
  output logic [31:0] deq_pc,
  output logic        misalign_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] fetch_pc;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [63:0] head;
  logic pop, push, has;
  assign imem_addr = fetch_pc;
  assign has = rst & (count != '0);
  assign head = mem[rd_ptr];
  assign deq_valid = has & ~redirect_valid;
  assign deq_pc = has ? head[63:32] : 32'd0;
  assign deq_instr = has ? head[31:0] : 32'd0;
  assign pop = deq_valid & deq_ready;
  assign push = rst & ~redirect_valid & ((count < FULL) | pop);
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) fetch_pc <= fetch_pc + 32'd4;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // storage is deliberately left uncleared by reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {fetch_pc, imem_rdata};
`ifdef IFQ_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) misalign_err <= 1'b0;
    else if (redirect_valid && redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
  end
`else
  assign misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: queue-level reference model checked every cycle plus directed literal checks.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  logic clk = 0, rst = 0, rst1 = 0, redirect_valid = 0, deq_ready = 1, mon = 0;
  logic [31:0] redirect_pc = 0;
  logic [31:0] imem_addr, imem_rdata, deq_instr, deq_pc;
  logic deq_valid, misalign_err;
  logic [31:0] u1_addr, u1_rdata, u1_instr, u1_pc;
  logic u1_valid, u1_err;
  logic [31:0] tbl [6] = '{32'h0062E233, 32'h00B67433, 32'h00B60933, 32'h41390433, 32'h015A4433, 32'h017B2433};
  logic [31:0] wrap [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  logic [7:0] pat = 8'b1011_0010;
  ent_t mq[$];
  logic [31:0] mpc = 0;
  logic merr = 0, exp_err;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(logic [31:0] a);
    return (a[31:2] < 6) ? tbl[a[4:2]] : ({a[31:2], 2'b11} ^ 32'h5A00_0000);
  endfunction
  assign imem_rdata = mem(imem_addr);
  assign u1_rdata = mem(u1_addr);
  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) u0 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_valid(deq_valid),
    .deq_ready(deq_ready), .deq_instr(deq_instr), .deq_pc(deq_pc), .misalign_err(misalign_err));
  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst(rst1), .imem_addr(u1_addr), .imem_rdata(u1_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .deq_valid(u1_valid),
    .deq_ready(1'b1), .deq_instr(u1_instr), .deq_pc(u1_pc), .misalign_err(u1_err));
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      mpc = 32'h0;
      merr = 0;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
`ifdef IFQ_ALIGN_CHECK_EN
      merr = merr | (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (mq.size() != 0 && deq_ready) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back('{mpc, mem(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  end
  always @(negedge clk) begin
    if (mon) begin
      chk("m_valid", 32'(deq_valid), 32'(rst && mq.size() != 0 && !redirect_valid));
      chk("m_addr", imem_addr, mpc);
      chk("m_pc", deq_pc, (rst && mq.size() != 0) ? mq[0].pc : 32'h0);
      chk("m_instr", deq_instr, (rst && mq.size() != 0) ? mq[0].instr : 32'h0);
      chk("m_err", 32'(misalign_err), 32'(merr));
    end
  end
  initial begin
`ifdef IFQ_ALIGN_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    repeat (2) step();
    mon = 1;
    #1;
    chk("rst_valid", 32'(deq_valid), 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", deq_pc, 0);
    chk("rst_instr", deq_instr, 0);
    chk("rst_err", 32'(misalign_err), 0);
    step();
    rst = 1; rst1 = 1;
    #1;
    chk("fill_valid", 32'(deq_valid), 0);
    chk("fill_addr", imem_addr, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      #1;
      chk("str_valid", 32'(deq_valid), 1);
      chk("str_pc", deq_pc, 32'(4 * i));
      chk("str_instr", deq_instr, tbl[i]);
      if (i < 4) chk("wrap_pc", u1_pc, wrap[i]);
    end
    step();
    redirect_valid = 1; redirect_pc = 0; deq_ready = 0;
    #1;
    chk("bp_redir_valid", 32'(deq_valid), 0);
    step();
    redirect_valid = 0;
    #1;
    chk("bp_start_addr", imem_addr, 0);
    repeat (4) step();
    #1;
    chk("bp_full_addr", imem_addr, 32'h10);
    chk("bp_head", deq_pc, 0);
    step();
    #1;
    chk("bp_hold_addr", imem_addr, 32'h10);
    deq_ready = 1;
    #1;
    chk("bp_pop_pc", deq_pc, 0);
    step();
    deq_ready = 0;
    #1;
    chk("bp_next_addr", imem_addr, 32'h14);
    chk("bp_next_pc", deq_pc, 32'h4);
    step();
    redirect_valid = 1; redirect_pc = 0;
    step();
    redirect_valid = 0;
    repeat (3) step();
    redirect_valid = 1; redirect_pc = 32'h8;
    #1;
    chk("rd_q3_addr", imem_addr, 32'hC);
    chk("rd_cyc_valid", 32'(deq_valid), 0);
    step();
    redirect_valid = 0; deq_ready = 1;
    #1;
    chk("rd_n1_valid", 32'(deq_valid), 0);
    chk("rd_n1_addr", imem_addr, 32'h8);
    step();
    #1;
    chk("rd_n2_valid", 32'(deq_valid), 1);
    chk("rd_n2_pc", deq_pc, 32'h8);
    chk("rd_n2_instr", deq_instr, 32'h00B60933);
    step();
    redirect_valid = 1; redirect_pc = 32'hC; deq_ready = 0;
    step();
    redirect_valid = 0;
    repeat (2) step();
    #1;
    chk("mr_addr", imem_addr, 32'h14);
    chk("mr_head", deq_pc, 32'hC);
    rst = 0;
    #1;
    chk("mr_low_valid", 32'(deq_valid), 0);
    chk("mr_low_pc", deq_pc, 0);
    step();
    rst = 1; deq_ready = 1;
    #1;
    chk("mr_rel_valid", 32'(deq_valid), 0);
    chk("mr_rel_addr", imem_addr, 0);
    step();
    #1;
    chk("mr_pc0", deq_pc, 0);
    step();
    #1;
    chk("mr_pc4", deq_pc, 32'h4);
    step();
    redirect_valid = 1; redirect_pc = 32'h6;
    step();
    redirect_valid = 0;
    #1;
    chk("mis_addr", imem_addr, 32'h4);
    chk("mis_err", 32'(misalign_err), 32'(exp_err));
    step();
    #1;
    chk("mis_pc", deq_pc, 32'h4);
    step();
    redirect_valid = 1; redirect_pc = 32'h0;
    step();
    redirect_valid = 0;
    #1;
    chk("mis_sticky", 32'(misalign_err), 32'(exp_err));
    for (int i = 0; i < 40; i++) begin
      step();
      deq_ready = pat[i % 8];
      redirect_valid = (i == 20);
      redirect_pc = 32'h1C;
    end
    step();
    mon = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
